// File: rtl/joystick_port_pkg.sv
// Shared constants and read-byte formatting for the joystick port.
package joystick_port_pkg;

  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_FIRE  = 4;
  localparam int JOY_BITS  = 5;

  // 0xBE00-0xBFFF window, A6=0, A4:A3=10
  localparam logic [15:0] JOY_DECODE_MASK  = 16'hFE58;
  localparam logic [15:0] JOY_DECODE_MATCH = 16'hBE10;

  typedef logic [JOY_BITS-1:0] joy_bits_t;

  // Active-low legacy layout; bit 7 low means the channel changed since last read.
  function automatic logic [7:0] joy_read_byte(input logic chg, input logic fire,
                                               input logic [3:0] dir);
    return {~chg, 2'b11, ~fire, ~dir[JOY_RIGHT], ~dir[JOY_LEFT], ~dir[JOY_DOWN], ~dir[JOY_UP]};
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// One joystick channel: two-flop synchroniser, stability debounce, change strobe.
module joy_debounce
  import joystick_port_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned DB_W      = 8
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  joy_bits_t joy_i,
  output joy_bits_t deb_o,
  output logic      chg_o
);

  joy_bits_t sync1_q, sync2_q;
  joy_bits_t deb_q, deb_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
    end else begin
      sync1_q <= joy_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
    end
  end

  generate
    if (DB_CYCLES == 0) begin : g_bypass
      always_comb begin
        deb_d = sync2_q;
      end
    end else begin : g_debounce
      localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

      joy_bits_t       prev_q;
      logic [DB_W-1:0] cnt_q, cnt_d;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          prev_q <= '0;
          cnt_q  <= '0;
        end else begin
          prev_q <= sync2_q;
          cnt_q  <= cnt_d;
        end
      end

      // Count only while the synced value is steady and differs from the accepted one.
      always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q == prev_q && sync2_q != deb_q) begin
          if (cnt_q == DB_LAST) begin
            deb_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    end
  endgenerate

  assign deb_o = deb_q;
  assign chg_o = (deb_d != deb_q);

endmodule

// File: rtl/joystick_port.sv
// Multi-channel joystick read port on the 6803 bus with debounce, autofire and change flags.
module joystick_port
  import joystick_port_pkg::*;
#(
  parameter int unsigned NUM_JOY   = 2,
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned DB_W      = 8,
  parameter int unsigned AF_HALF   = 50000
) (
  input  logic [NUM_JOY*16-1:0] joy,
  input  logic [NUM_JOY-1:0]    autofire_en,
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [15:0]           addr,
  input  logic                  rd,
  output logic [7:0]            dout,
  output logic                  sel
);

  localparam int unsigned AF_W = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;
  localparam int unsigned CH_W = (NUM_JOY > 1) ? $clog2(NUM_JOY) : 1;
  localparam logic [AF_W-1:0] AF_LAST = AF_W'(AF_HALF - 1);

  joy_bits_t          deb [NUM_JOY];
  logic [NUM_JOY-1:0] deb_chg;
  logic [NUM_JOY-1:0] fire;
  logic [NUM_JOY-1:0] chg_q, chg_d, chg_clr;
  logic [AF_W-1:0]    af_cnt_q, af_cnt_d;
  logic               af_phase_q, af_phase_d;
  logic [7:0]         dout_q, dout_d, rd_byte;
  logic               sel_q, sel_d;
  logic               hit;
  logic [CH_W-1:0]    ch;

  genvar g;
  generate
    for (g = 0; g < NUM_JOY; g++) begin : g_chan
      logic unused_hi;
      assign unused_hi = ^joy[16*g+JOY_BITS +: 16-JOY_BITS];

      joy_debounce #(
        .DB_CYCLES(DB_CYCLES),
        .DB_W     (DB_W)
      ) u_deb (
        .clk_i (clk),
        .rst_ni(reset_n),
        .joy_i (joy[16*g +: JOY_BITS]),
        .deb_o (deb[g]),
        .chg_o (deb_chg[g])
      );

      assign fire[g] = deb[g][JOY_FIRE] & (~autofire_en[g] | af_phase_q);
    end

    if (NUM_JOY == 1) begin : g_ch1
      assign ch = '0;
    end else if (CH_W == 1) begin : g_ch2
      assign ch = addr[2];
    end else begin : g_ch4
      assign ch = {addr[7], addr[2]};
    end
  endgenerate

  assign hit = ((addr & JOY_DECODE_MASK) == JOY_DECODE_MATCH);

  always_comb begin
    af_cnt_d   = af_cnt_q + 1'b1;
    af_phase_d = af_phase_q;
    if (af_cnt_q == AF_LAST) begin
      af_cnt_d   = '0;
      af_phase_d = ~af_phase_q;
    end
  end

  // Unpopulated channel indices read as all-released and touch no flag.
  always_comb begin
    rd_byte = 8'hFF;
    chg_clr = '0;
    for (int unsigned i = 0; i < NUM_JOY; i++) begin
      if (32'(ch) == i) begin
        rd_byte    = joy_read_byte(chg_q[i], fire[i], deb[i][3:0]);
        chg_clr[i] = rd & hit;
      end
    end
  end

  always_comb begin
    chg_d  = deb_chg | (chg_q & ~chg_clr);
    sel_d  = rd & hit;
    dout_d = (rd & hit) ? rd_byte : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt_q   <= '0;
      af_phase_q <= 1'b0;
      chg_q      <= '0;
      dout_q     <= '0;
      sel_q      <= 1'b0;
    end else begin
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
      chg_q      <= chg_d;
      dout_q     <= dout_d;
      sel_q      <= sel_d;
    end
  end

  assign dout = dout_q;
  assign sel  = sel_q;

endmodule

// File: doc/joystick_port.md
Name: joystick_port

Overview:
- Parametrised successor to the MC-10 combinational joystick read decoder; serves 1–4 joysticks on the 6803 data bus at the same 0xBE00–0xBFFF alias window.
- Adds per-channel input synchronisation, debounce, optional autofire on the fire button, and a sticky "changed since last read" flag per channel.
- Output is registered and OR-combined onto the CPU read bus: 0x00 when not selected.

Parameters:
- NUM_JOY, 2, number of joystick channels (1..4).
- DB_CYCLES, 16, clk cycles a new input value must be stable before it is accepted; 0 = debounce bypassed.
- DB_W, 8, debounce counter width; must satisfy DB_CYCLES < 2**DB_W.
- AF_HALF, 50000, clk cycles per autofire half-period; must be ≥1.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- joy, input, NUM_JOY*16, MiSTer joystick words, channel i at [16i+15:16i], active-high; bit0 right, bit1 left, bit2 down, bit3 up, bit4 fire.
- autofire_en, input, NUM_JOY, per-channel autofire enable (quasi-static OSD setting).
- addr, input, 16, CPU address.
- rd, input, 1, CPU read strobe, one clk wide per access.
- dout, output, 8, registered read data.
- sel, output, 1, registered: high when dout carries a valid joystick read.

Behaviour:
- Decode: hit = addr[15:9]==7'b1011111 & addr[6]==0 & addr[4:3]==2'b10.
- Channel index ch = {addr[7],addr[2]}, truncated to clog2(NUM_JOY) bits; NUM_JOY==1 forces ch=0.
- Sync: joy[4:0] of every channel passes through two flops (reset 0). Bits 15:5 are ignored.
- Debounce, per channel:
  - prev holds the last synced value; cnt is DB_W bits; deb holds the accepted value (reset 0).
  - If synced != prev, cnt <= 0.
  - Else if synced != deb: cnt increments; when cnt == DB_CYCLES-1, deb <= synced and cnt <= 0.
  - Else cnt <= 0.
  - A change is therefore accepted DB_CYCLES+1 clks after the synced value settles.
  - DB_CYCLES==0: deb <= synced every clk.
- Autofire:
  - One shared prescaler counts 0..AF_HALF-1, then wraps and toggles af_phase. Both reset to 0.
  - Reported fire = deb[4] & (~autofire_en[i] | af_phase).
  - Autofire never affects direction bits.
- Change flag chg[i]:
  - Set whenever deb[i] updates to a different value.
  - Cleared by a read of channel i (rd & hit & ch==i).
  - If set and clear occur on the same edge, set wins.
  - Reset value 0.
- Read byte for channel i: {~chg[i], 2'b11, ~fire_i, ~deb[0], ~deb[1], ~deb[2], ~deb[3]}. Bits 6:0 match the legacy layout; bit 7 is 0 = changed since last read.
- ch >= NUM_JOY: read byte is 0xFF and no chg is touched.
- Output register:
  - Each clk, sel <= rd & hit; dout <= (rd & hit) ? read byte : 8'h00.
  - Latency 1 clk from rd to valid dout.
  - The byte samples chg before its clear (read-then-clear).
- Reset: dout=0x00, sel=0, all internal state cleared immediately and asynchronously. Debounce and chg restart cleanly if reset asserts mid-count.

Decomposition:
- Shared package:
  - Joystick bit indices (JOY_RIGHT=0, LEFT=1, DOWN=2, UP=3, FIRE=4).
  - JOY_DECODE_MASK/MATCH constants for the address decode.
- One sub-module, joy_debounce: a single channel's 5-bit sync + debounce + change-strobe output, instantiated NUM_JOY times via generate.
- Prescaler, chg flags and read mux live in the top module.

Test Plan:
- Reset: NUM_JOY=2, DB_CYCLES=4, no input, read 0xBF30 → next clk dout=0xFF, sel=1; the following clk with rd=0 → dout=0x00, sel=0.
- Debounce: joy[3]=1 on ch0, held; read 0xBF30 every clk → 0xFF until the expected accept cycle, then 0x7E (bit7 chg=0, up=0). A 2-clk glitch on joy[0] is never accepted.
- Change flag: after the accept, first read of 0xBF30 → 0x7E, second read → 0xFE. A read of 0xBF34 (ch1) in between leaves ch0's flag set.
- Autofire: AF_HALF=3, autofire_en=01, ch0 fire held → successive reads of 0xBF30 alternate bit4 between 0 and 1 every 3 clks. Same stimulus on ch1 with en=0 → bit4 steady 0.
- Decode: addresses 0xBE10, 0xBF90, 0xBFB0 → sel=1; addresses 0xBF70 (addr6=1) and 0xBF20 (addr4:3=00) → dout=0x00, sel=0. NUM_JOY=2 read of 0xBFB4 maps to ch1.
- Simultaneous events and reset: set and clear of chg on the same edge → the next read returns bit7=0. Asserting reset_n=0 mid-debounce → dout=0x00 immediately; after release, the input re-debounces from cnt=0.
